// File: rtl/psum_cmd_dispatcher.sv
// Request buffer in front of the hybrid DRAM/IMC controller: queues compute-array
// requests, issues them one per cycle, and turns returned read data into a response strobe.
module psum_cmd_dispatcher #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_type,
  input  logic                  req_accum,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ACC_WIDTH-1:0]  req_data,
  input  logic                  issue_en,
  output logic                  cmd_valid,
  output logic                  cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [ACC_WIDTH-1:0]  write_data,
  output logic                  accumulate_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [15:0]           cmd_count,
  output logic                  idle
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 2 + ADDR_WIDTH + ACC_WIDTH;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        fill_cnt_reg;
  logic [1:0]            rd_pipe_reg;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  head_type;
  logic                  head_accum;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [ACC_WIDTH-1:0]  head_data;

  assign fifo_empty = (fill_cnt_reg == '0);
  assign fifo_full  = (fill_cnt_reg == FULL_CNT);
  // Ready comes from pre-edge occupancy, so a full FIFO refuses a push even while popping.
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign pop        = issue_en && !fifo_empty;
  assign {head_type, head_accum, head_addr, head_data} = fifo_mem[rd_ptr_reg];

  // Accumulate is meaningless on a read, so it is cleared before storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_type, req_accum & req_type, req_addr, req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) begin
        fill_cnt_reg <= fill_cnt_reg + 1'b1;
      end else if (pop && !push) begin
        fill_cnt_reg <= fill_cnt_reg - 1'b1;
      end
    end
  end

  // Command fields hold their last values while cmd_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid     <= 1'b0;
      cmd_type      <= 1'b0;
      cmd_addr      <= '0;
      write_data    <= '0;
      accumulate_en <= 1'b0;
      cmd_count     <= '0;
    end else begin
      cmd_valid <= pop;
      cmd_count <= cmd_count + 16'(cmd_valid);
      if (pop) begin
        cmd_type      <= head_type;
        cmd_addr      <= head_addr;
        write_data    <= head_data;
        accumulate_en <= head_accum;
      end
    end
  end

  // Controller returns read data one cycle after the command; read_valid is not trustworthy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_reg <= 2'b00;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rd_pipe_reg <= {rd_pipe_reg[0], pop && !head_type};
      rsp_valid   <= rd_pipe_reg[1];
      if (rd_pipe_reg[1]) rsp_data <= read_data;
    end
  end

  assign idle = fifo_empty && !cmd_valid && !rd_pipe_reg[0] && !rd_pipe_reg[1];
endmodule

// File: tb/tb_psum_cmd_dispatcher.sv
// Randomised and directed bench for psum_cmd_dispatcher against a queue-based
// transaction model of the request FIFO, command bus and read responses.
module tb_psum_cmd_dispatcher;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_type;
  logic        req_accum;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        issue_en;
  logic        cmd_valid;
  logic        cmd_type;
  logic [15:0] cmd_addr;
  logic [15:0] write_data;
  logic        accumulate_en;
  logic [7:0]  read_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] cmd_count;
  logic        idle;

  psum_cmd_dispatcher #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .ACC_WIDTH(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_accum(req_accum), .req_addr(req_addr), .req_data(req_data),
    .issue_en(issue_en), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .write_data(write_data), .accumulate_en(accumulate_en), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd_count(cmd_count), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          t;
    bit          a;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  req_t        mq[$];
  bit          m_cmd_valid, m_cmd_type, m_accum, m_rsp_valid, m_ready, m_idle, m_acc, m_rd_last;
  logic [15:0] m_cmd_addr, m_write_data, m_count;
  logic [7:0]  m_rsp_data;
  bit          rand_rd;
  int          n_tests, n_fail;

  task automatic model_reset();
    mq.delete();
    m_cmd_valid = 0; m_cmd_type = 0; m_accum = 0; m_rsp_valid = 0;
    m_ready = 1; m_idle = 1; m_acc = 0; m_rd_last = 0;
    m_cmd_addr = '0; m_write_data = '0; m_count = '0; m_rsp_data = '0;
  endtask

  // Advance one clock edge; the model applies the transaction rules to the pre-edge inputs.
  task automatic tick();
    bit   rdy, old_v, old_t;
    req_t e;
    if (rand_rd) read_data = 8'($urandom);
    rdy   = (mq.size() < DEPTH);
    m_acc = req_valid && rdy;
    old_v = m_cmd_valid;
    old_t = m_cmd_type;
    m_count     = m_count + 16'(old_v);
    m_rsp_valid = m_rd_last;
    if (m_rd_last) m_rsp_data = read_data;
    m_rd_last   = old_v && !old_t;
    if (issue_en && mq.size() > 0) begin
      e = mq.pop_front();
      m_cmd_valid = 1; m_cmd_type = e.t; m_cmd_addr = e.addr;
      m_write_data = e.data; m_accum = e.a && e.t;
    end else begin
      m_cmd_valid = 0;
    end
    if (m_acc) mq.push_back('{req_type, req_accum, req_addr, req_data});
    m_ready = (mq.size() < DEPTH);
    m_idle  = (mq.size() == 0) && !m_cmd_valid && !(old_v && !old_t);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 0; req_type = 0; req_accum = 0; req_addr = '0; req_data = '0;
    issue_en = 0; read_data = '0; rand_rd = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en} !== 35'd0) begin
      n_fail++; $display("FAIL reset_cmd: got %h expected 0", {cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en});
    end
    n_tests++;
    if ({rsp_valid, rsp_data, cmd_count} !== 25'd0) begin
      n_fail++; $display("FAIL reset_rsp_count: got %h expected 0", {rsp_valid, rsp_data, cmd_count});
    end
    n_tests++;
    if ({req_ready, idle} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready_idle: got %b expected 11", {req_ready, idle});
    end
    rst_n = 1;
    model_reset();
    tick();
    n_tests++;
    if ({cmd_valid, rsp_valid, idle} !== 3'b001) begin
      n_fail++; $display("FAIL post_reset_quiet: got %b expected 001", {cmd_valid, rsp_valid, idle});
    end
  endtask

  task automatic test_single_accum();
    issue_en = 1;
    req_valid = 1; req_type = 1; req_accum = 1; req_addr = 16'h0010; req_data = 16'h0005;
    tick();
    req_valid = 0;
    n_tests++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL accum_early: got cmd_valid=%b expected 0", cmd_valid);
    end
    tick();
    n_tests++;
    if ({cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en} !== {1'b1, 1'b1, 16'h0010, 16'h0005, 1'b1}) begin
      n_fail++; $display("FAIL accum_cmd: got %h expected %h",
        {cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en}, {1'b1, 1'b1, 16'h0010, 16'h0005, 1'b1});
    end
    tick();
    n_tests++;
    if ({cmd_valid, cmd_count, idle} !== {1'b0, m_count, 1'b1} || m_count != 16'd1) begin
      n_fail++; $display("FAIL accum_after: got v=%b cnt=%0d idle=%b expected v=0 cnt=1 idle=1", cmd_valid, cmd_count, idle);
    end
  endtask

  task automatic test_write_read();
    int pulses;
    logic [7:0] seen;
    pulses = 0; seen = '0;
    rand_rd = 0; read_data = 8'h7F; issue_en = 1;
    req_valid = 1; req_type = 1; req_accum = 0; req_addr = 16'h0020; req_data = 16'h007F;
    tick();
    req_type = 0; req_data = 16'hBEEF;
    tick();
    req_valid = 0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if ({cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en} !==
          {m_cmd_valid, m_cmd_type, m_cmd_addr, m_write_data, m_accum}) begin
        n_fail++; $display("FAIL wr_rd_cmd c%0d: got %h expected %h", c,
          {cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en},
          {m_cmd_valid, m_cmd_type, m_cmd_addr, m_write_data, m_accum});
      end
      if (rsp_valid) begin pulses++; seen = rsp_data; end
      tick();
    end
    n_tests++;
    if (pulses != 1 || seen !== 8'h7F) begin
      n_fail++; $display("FAIL wr_rd_rsp: got %0d pulses data %h expected 1 pulse data 7f", pulses, seen);
    end
    rand_rd = 1;
  endtask

  task automatic test_read_accum();
    bit got;
    got = 0;
    issue_en = 1;
    req_valid = 1; req_type = 0; req_accum = 1; req_addr = 16'h0001; req_data = 16'hFFFF;
    tick();
    req_valid = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cmd_valid) begin
        got = 1;
        n_tests++;
        if ({cmd_type, cmd_addr, accumulate_en} !== {1'b0, 16'h0001, 1'b0}) begin
          n_fail++; $display("FAIL rd_accum: got type=%b addr=%h acc=%b expected 0 0001 0", cmd_type, cmd_addr, accumulate_en);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL rd_accum_issue: got no command expected one");
    end
  endtask

  // Fills the buffer with issue held off, then streams; start_full also streams new pushes.
  task automatic run_stream(input string name, input int n_req, input int hold_cycles);
    logic [15:0] issued[$];
    int k, first, last;
    k = 0; first = -1; last = -1;
    issue_en = 0;
    for (int c = 0; c < hold_cycles; c++) begin
      req_valid = (k < n_req); req_type = 1; req_accum = 0;
      req_addr = 16'(k); req_data = 16'(k * 3);
      tick();
      if (m_acc) k++;
      n_tests++;
      if (cmd_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s_stall c%0d: got cmd_valid=%b expected 0", name, c, cmd_valid);
      end
    end
    n_tests++;
    if (req_ready !== 1'b0 || k != DEPTH) begin
      n_fail++; $display("FAIL %s_full: got ready=%b accepts=%0d expected ready=0 accepts=%0d", name, req_ready, k, DEPTH);
    end
    issue_en = 1;
    for (int c = 0; c < n_req + 4; c++) begin
      req_valid = (k < n_req); req_addr = 16'(k); req_data = 16'(k * 3);
      tick();
      if (m_acc) k++;
      n_tests++;
      if ({cmd_valid, cmd_addr, write_data, req_ready} !== {m_cmd_valid, m_cmd_addr, m_write_data, m_ready}) begin
        n_fail++; $display("FAIL %s_cmd c%0d: got %h expected %h", name, c,
          {cmd_valid, cmd_addr, write_data, req_ready}, {m_cmd_valid, m_cmd_addr, m_write_data, m_ready});
      end
      if (cmd_valid) begin
        issued.push_back(cmd_addr);
        if (first < 0) first = c;
        last = c;
      end
    end
    req_valid = 0;
    n_tests++;
    if (issued.size() != n_req || (last - first + 1) != n_req) begin
      n_fail++; $display("FAIL %s_count: got %0d cmds over %0d cycles expected %0d consecutive",
        name, issued.size(), last - first + 1, n_req);
    end
    for (int i = 0; i < issued.size(); i++) begin
      n_tests++;
      if (issued[i] !== 16'(i)) begin
        n_fail++; $display("FAIL %s_order i%0d: got %h expected %h", name, i, issued[i], 16'(i));
      end
    end
  endtask

  task automatic test_fill_stall();
    run_stream("fill5", 5, 7);
  endtask

  task automatic test_back_to_back();
    run_stream("full8", 8, 5);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_type  = 1'($urandom);
      req_accum = 1'($urandom);
      req_addr  = 16'($urandom_range(0, 31));
      req_data  = 16'($urandom);
      issue_en  = ($urandom_range(0, 3) != 0);
      tick();
      n_tests++;
      if ({cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en} !==
          {m_cmd_valid, m_cmd_type, m_cmd_addr, m_write_data, m_accum}) begin
        n_fail++; $display("FAIL rand_cmd c%0d: got %h expected %h", c,
          {cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en},
          {m_cmd_valid, m_cmd_type, m_cmd_addr, m_write_data, m_accum});
      end
      n_tests++;
      if ({rsp_valid, rsp_data} !== {m_rsp_valid, m_rsp_data}) begin
        n_fail++; $display("FAIL rand_rsp c%0d: got %h expected %h", c, {rsp_valid, rsp_data}, {m_rsp_valid, m_rsp_data});
      end
      n_tests++;
      if ({req_ready, idle, cmd_count} !== {m_ready, m_idle, m_count}) begin
        n_fail++; $display("FAIL rand_status c%0d: got %h expected %h", c, {req_ready, idle, cmd_count}, {m_ready, m_idle, m_count});
      end
    end
    req_valid = 0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_read();
    int rsp_seen, cmd_seen;
    rsp_seen = 0; cmd_seen = 0;
    issue_en = 1;
    req_valid = 1; req_type = 0; req_accum = 0; req_addr = 16'h0042; req_data = '0;
    tick();
    req_valid = 0;
    tick();
    n_tests++;
    if ({cmd_valid, cmd_type} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_issue: got v/t=%b expected 10", {cmd_valid, cmd_type});
    end
    tick();
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en, rsp_valid, rsp_data, cmd_count} !== 60'd0
        || {req_ready, idle} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_async: got %h ready/idle %b expected 0 ready/idle 11",
        {cmd_valid, cmd_type, cmd_addr, write_data, accumulate_en, rsp_valid, rsp_data, cmd_count}, {req_ready, idle});
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid) rsp_seen++;
      if (cmd_valid) cmd_seen++;
    end
    n_tests++;
    if (rsp_seen != 0 || cmd_seen != 0 || cmd_count !== 16'd0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL midrst_after: got rsp=%0d cmd=%0d cnt=%0d idle=%b expected 0 0 0 1",
        rsp_seen, cmd_seen, cmd_count, idle);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    test_reset();
    test_single_accum();
    test_write_read();
    test_read_accum();
    test_fill_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_cmd_dispatcher.md
# psum_cmd_dispatcher

Front-end stage that feeds the hybrid DRAM/IMC controller. It accepts read, plain-write and accumulate requests from the compute array over a valid/ready handshake and buffers them in a small FIFO. It issues them to the controller at most one per cycle on the controller's command bus, which has no backpressure. It also captures read data returned by the controller and presents it as a single-cycle response.

## Interface
- ADDR_WIDTH, 16, address width; matches controller cmd_addr
- DATA_WIDTH, 8, stored word width; matches controller read_data
- ACC_WIDTH, 16, partial-sum width; matches controller write_data
- FIFO_DEPTH, 4, request buffer entries; power of two, ≥2

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  upstream request present
- req_ready  out  1  dispatcher can accept; equals !full
- req_type  in  1  0=read, 1=write
- req_accum  in  1  accumulate flag; ignored for reads
- req_addr  in  ADDR_WIDTH  target address
- req_data  in  ACC_WIDTH  write/accumulate operand; ignored for reads
- issue_en  in  1  1=issue allowed; 0=hold (refresh/stall window)
- cmd_valid  out  1  to controller
- cmd_type  out  1  to controller
- cmd_addr  out  ADDR_WIDTH  to controller
- write_data  out  ACC_WIDTH  to controller
- accumulate_en  out  1  to controller; forced 0 on reads
- read_data  in  DATA_WIDTH  from controller
- rsp_valid  out  1  read response strobe, one cycle
- rsp_data  out  DATA_WIDTH  read response data
- cmd_count  out  16  commands issued; wraps 0xFFFF→0
- idle  out  1  FIFO empty, cmd_valid=0, no read in flight

## Operation
- Push: request is accepted on a rising edge with req_valid & req_ready. Fields are stored as {type, accum&type, addr, data}.
- Pop: on each edge with issue_en=1 and the FIFO non-empty, the head is loaded into the cmd_* registers with cmd_valid=1. Otherwise cmd_valid←0.
- While cmd_valid=0, cmd_type, cmd_addr, write_data and accumulate_en hold their last values.
- Push and pop may occur on the same edge, including when the FIFO is full. req_ready reflects pre-edge occupancy, so no push is accepted while full, even if a pop happens on that edge.
- Order is strict FIFO. No reordering and no address-hazard logic is needed: the controller commits each write at its edge, and a following read or accumulate to the same address one cycle later sees the committed value.
- Read tracking:
  - On the cycle cmd_valid=1 with cmd_type=0, set rd_pipe[0].
  - rd_pipe[0]→rd_pipe[1] on the next edge.
  - When rd_pipe[1] is set, capture read_data into rsp_data and pulse rsp_valid.
  - The controller's read_valid is NOT used: it stays high across back-to-back commands.
- Back-to-back reads produce back-to-back rsp_valid pulses, in issue order.
- rsp has no backpressure; the consumer must take it.
- cmd_count increments by 1 on every cycle with cmd_valid=1.
- idle = FIFO empty & !cmd_valid & !rd_pipe[0] & !rd_pipe[1].

## Timing
- Reset values:
  - req_ready=1, cmd_valid=0, cmd_type=0, cmd_addr=0, write_data=0, accumulate_en=0
  - rsp_valid=0, rsp_data=0, cmd_count=0, idle=1
  - FIFO empty, rd_pipe cleared
- Request→command: a request accepted at edge k drives cmd_valid=1 after edge k+1, provided issue_en=1 and it is the FIFO head.
- Read command→response: if cmd_valid=1 (read) in cycle c, then rsp_valid=1 in cycle c+2 with the controller's read_data from cycle c+1.
- Issue throughput: 1 command/cycle; sustained full-rate streaming with FIFO_DEPTH≥2.
- issue_en low: cmd_valid=0 starting the cycle after issue_en is sampled low. Pushes continue until full. A read already issued still completes its response.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous).
  - Buffered requests and in-flight responses are discarded.
  - No spurious cmd_valid or rsp_valid after release.

## Test plan
- Single accumulate: addr=0x0010, data=0x0005, accum=1 → one cmd_valid pulse 2 cycles after accept; accumulate_en=1, write_data=0x0005; cmd_count=1; idle returns to 1.
- Write then read: write addr 0x0020 data 0x007F, then read 0x0020, both back-to-back → cmd_valid high 2 consecutive cycles; rsp_valid pulses once, 2 cycles after the read command, with rsp_data=0x7F.
- Read with accum flag: read req_accum=1 to addr 0x0001 → accumulate_en=0 on the issued command.
- Fill/stall: issue_en=0, push 5 requests with FIFO_DEPTH=4 → req_ready=0 after 4 accepts and the 5th is held. Then issue_en=1 → 4 commands issue in order on consecutive cycles, then the 5th; no cmd_valid during the stall.
- Full with simultaneous push/pop: FIFO full, issue_en=1, req_valid held → exactly one command per cycle and one accept per cycle after the first pop; no loss or duplication (check addresses 0..7 in order).
- Reset mid-read: read issued, rst_n low in the next cycle → rsp_valid never asserts; all outputs at reset values; cmd_count=0.
